// File: rtl/dot_product_ctrl_if.sv
// Bus bundle between dot_product_ctrl and its requester/multiplier side.
//
// Signals:
//   go         requester -> ctrl   start a 4-pair dot product (honoured in IDLE)
//   a_vec      requester -> ctrl   four unsigned 4-bit operands, a0 in [3:0]
//   b_vec      requester -> ctrl   four unsigned 4-bit operands, b0 in [3:0]
//   mul_a      ctrl -> multiplier  operand A of the current pair
//   mul_b      ctrl -> multiplier  operand B of the current pair
//   mul_start  ctrl -> multiplier  one-cycle start pulse
//   mul_result multiplier -> ctrl  unsigned 9-bit product
//   mul_ready  multiplier -> ctrl  idle / result-valid level
//   sum        ctrl -> requester   accumulated dot product
//   done       ctrl -> requester   one-cycle pulse when sum is final
//   busy       ctrl -> requester   high in every state except IDLE
//   err        ctrl -> requester   sticky multiplier-timeout flag
//
// master: the requester/multiplier side; slave: the controller.
interface dot_product_ctrl_if;
  logic        go;
  logic [15:0] a_vec;
  logic [15:0] b_vec;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic        mul_start;
  logic [8:0]  mul_result;
  logic        mul_ready;
  logic [10:0] sum;
  logic        done;
  logic        busy;
  logic        err;

  modport master (
    output go, a_vec, b_vec, mul_result, mul_ready,
    input  mul_a, mul_b, mul_start, sum, done, busy, err
  );

  modport slave (
    input  go, a_vec, b_vec, mul_result, mul_ready,
    output mul_a, mul_b, mul_start, sum, done, busy, err
  );
endinterface

// File: rtl/dot_product_ctrl.sv
// dot_product_ctrl: sequences four operand pairs through an external
// multiplier and accumulates the products into an 11-bit dot product.
//
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous active-high reset
//   bus    dot_product_ctrl_if.slave (go, a_vec, b_vec, mul_*, sum, done,
//          busy, err)
//
// Parameter TIMEOUT_CYC: maximum WAIT cycles per pair before the run is
// aborted with err set.
module dot_product_ctrl #(
  parameter int TIMEOUT_CYC = 63
) (
  input  logic              clk,
  input  logic              reset,
  dot_product_ctrl_if.slave bus
);

  localparam int DATA_W = 4;
  localparam int PROD_W = 9;
  localparam int SUM_W  = 11;
  // Counter holds 0..TIMEOUT_CYC-1; the abort fires on the last value.
  localparam int TCNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_ACC,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [4*DATA_W-1:0]   a_lat_q, b_lat_q;
  logic [1:0]            idx_q;
  logic [TCNT_W-1:0]     tcnt_q;
  logic [PROD_W-1:0]     prod_q;
  logic [SUM_W-1:0]      sum_q;
  logic                  err_q;

  logic accept, capture, acc_en, abort, tcnt_clr, tcnt_inc;

  function automatic logic [DATA_W-1:0] pick(input logic [4*DATA_W-1:0] v,
                                             input logic [1:0] i);
    return v[i*DATA_W +: DATA_W];
  endfunction

  // 4 * 15 * 15 = 900 fits in 11 bits, so plain widening add cannot wrap.
  function automatic logic [SUM_W-1:0] acc_add(input logic [SUM_W-1:0] s,
                                               input logic [PROD_W-1:0] p);
    return s + SUM_W'(p);
  endfunction

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    acc_en   = 1'b0;
    abort    = 1'b0;
    tcnt_clr = 1'b0;
    tcnt_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_SETTLE;
      S_SETTLE: begin
        // mul_ready may still show the previous result here; ignore it.
        tcnt_clr = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mul_ready) begin
          capture = 1'b1;
          state_d = S_ACC;
        end else if (tcnt_q == TCNT_LAST) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      S_ACC: begin
        acc_en  = 1'b1;
        state_d = (idx_q == 2'd3) ? S_DONE : S_ISSUE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_lat_q <= '0;
      b_lat_q <= '0;
      idx_q   <= '0;
      tcnt_q  <= '0;
      prod_q  <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_lat_q <= bus.a_vec;
        b_lat_q <= bus.b_vec;
        idx_q   <= '0;
        sum_q   <= '0;
        err_q   <= 1'b0;
      end
      if (tcnt_clr) begin
        tcnt_q <= '0;
      end else if (tcnt_inc) begin
        tcnt_q <= tcnt_q + TCNT_W'(1);
      end
      // capture stage: product registered on the WAIT -> ACC boundary
      if (capture) begin
        prod_q <= bus.mul_result;
      end
      // accumulate stage: one product folded in per ACC cycle
      if (acc_en) begin
        sum_q <= acc_add(sum_q, prod_q);
        // Index stays on the last pair so operands remain stable afterwards.
        if (idx_q != 2'd3) begin
          idx_q <= idx_q + 2'd1;
        end
      end
      if (abort) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.mul_a     = pick(a_lat_q, idx_q);
  assign bus.mul_b     = pick(b_lat_q, idx_q);
  assign bus.mul_start = (state_q == S_ISSUE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.sum       = sum_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Self-checking bench for dot_product_ctrl: a latency-configurable
// multiplier model, a schedule-level reference model of the expected
// outputs, a per-cycle compare process, and directed plus random runs.
module tb_dot_product_ctrl;

  localparam int TO = 63;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [15:0] a_vec = '0;
  logic [15:0] b_vec = '0;
  logic        mm_ready = 1'b1;
  logic [8:0]  mm_result = '0;

  always #5 clk = ~clk;

  dot_product_ctrl_if bus();
  assign bus.go         = go;
  assign bus.a_vec      = a_vec;
  assign bus.b_vec      = b_vec;
  assign bus.mul_ready  = mm_ready;
  assign bus.mul_result = mm_result;

  dot_product_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Multiplier: result and ready appear L edges after the start pulse;
  // the issue numbered cur_stall (counted from the accepted go) never answers.
  int         cur_L = 8;
  int         cur_stall = 4;
  int         mm_rem = 0;
  int         mm_n = 0;
  logic [8:0] mm_p = '0;

  always @(posedge clk) begin
    if (bus.mul_start) begin
      mm_ready <= 1'b0;
      mm_p     <= 9'(bus.mul_a) * 9'(bus.mul_b);
      mm_rem   <= (mm_n == cur_stall) ? 0 : cur_L;
      mm_n     <= mm_n + 1;
    end else if (mm_rem > 0) begin
      if (mm_rem == 1) begin
        mm_ready  <= 1'b1;
        mm_result <= mm_p;
      end
      mm_rem <= mm_rem - 1;
    end
    if (reset || (go && !bus.busy)) mm_n <= 0;
  end

  // Reference model: a run accepted at edge G occupies cycles rel = 0..end-1
  // with pair k spanning rel k*P .. k*P+P-1 (P = 3 + latency); DONE at rel 4P.
  int  cyc = 0;
  bit  m_active = 0;
  int  m_G = 0, m_L = 1, m_stall = 4, m_end = 0;
  int  m_a[4], m_b[4];
  bit  m_err = 0, m_post = 1;
  int  m_idle_sum = 0;

  function automatic int psum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += m_a[i] * m_b[i];
    return s;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_active   <= 0;
      m_err      <= 0;
      m_post     <= 1;
      m_idle_sum <= 0;
    end else if (!m_active && go) begin
      m_active <= 1;
      m_G      <= cyc + 1;
      m_L      <= cur_L;
      m_stall  <= cur_stall;
      m_err    <= 0;
      m_post   <= 0;
      for (int i = 0; i < 4; i++) begin
        m_a[i] <= int'(a_vec[i*4 +: 4]);
        m_b[i] <= int'(b_vec[i*4 +: 4]);
      end
      m_end <= (cur_stall < 4) ? cur_stall * (3 + cur_L) + 2 + TO
                               : 4 * (3 + cur_L) + 1;
    end else if (m_active && (cyc + 1 - m_G) == m_end) begin
      m_active <= 0;
      if (m_stall < 4) begin
        m_err      <= 1;
        m_idle_sum <= psum(m_stall);
      end else begin
        m_idle_sum <= psum(4);
      end
    end
  end

  always @(negedge clk) begin
    int rel, p, idx;
    if (cyc > 0) begin
      if (m_active) begin
        p   = 3 + m_L;
        rel = cyc - m_G;
        idx = rel / p;
        if (idx > m_stall) idx = m_stall;
        check("busy", int'(bus.busy), 1);
        check("done", int'(bus.done), int'(m_stall == 4 && rel == 4 * p));
        check("mul_start", int'(bus.mul_start),
              int'(rel % p == 0 && rel / p < 4 && rel / p <= m_stall));
        check("sum_run", int'(bus.sum), psum(idx));
        check("err_run", int'(bus.err), 0);
        if (idx < 4) begin
          check("mul_a", int'(bus.mul_a), m_a[idx]);
          check("mul_b", int'(bus.mul_b), m_b[idx]);
        end
      end else begin
        check("busy_idle", int'(bus.busy), 0);
        check("done_idle", int'(bus.done), 0);
        check("start_idle", int'(bus.mul_start), 0);
        check("sum_idle", int'(bus.sum), m_idle_sum);
        check("err_idle", int'(bus.err), int'(m_err));
        if (m_post) begin
          check("mul_a_rst", int'(bus.mul_a), 0);
          check("mul_b_rst", int'(bus.mul_b), 0);
        end
      end
    end
  end

  // Event log for the directed literal checks.
  int         done_cnt = 0;
  int         start_cnt = 0;
  int         last_done_cyc = 0;
  logic [7:0] pairs[$];

  always @(posedge clk) begin
    if (bus.done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
    if (bus.mul_start) begin
      start_cnt <= start_cnt + 1;
      pairs.push_back({bus.mul_a, bus.mul_b});
    end
  end

  int go_cyc = 0;

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_start"}, int'(bus.mul_start), 0);
    check({tag, "_err"}, int'(bus.err), 0);
    check({tag, "_sum"}, int'(bus.sum), 0);
    check({tag, "_mul_a"}, int'(bus.mul_a), 0);
    check({tag, "_mul_b"}, int'(bus.mul_b), 0);
  endtask

  // Called at a negedge with the DUT idle; returns at the first idle negedge.
  task automatic run(input logic [15:0] a, input logic [15:0] b, input int lat,
                     input int stall, input int rst_rel, input bit noise,
                     output int rel_out);
    int rel = 0;
    cur_L     = lat;
    cur_stall = stall;
    a_vec     = a;
    b_vec     = b;
    go        = 1'b1;
    @(negedge clk);
    go     = 1'b0;
    go_cyc = cyc;
    for (int n = 0; n < 600; n++) begin
      if (!bus.busy) break;
      if (rel == rst_rel) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rel++;
        check_all_zero("midrun_reset");
      end else begin
        if (noise) begin
          go    = 1'($urandom_range(0, 1));
          a_vec = 16'($urandom);
          b_vec = 16'($urandom);
        end
        @(negedge clk);
        rel++;
      end
    end
    go = 1'b0;
    if (bus.busy) check("run_bounded", 1, 0);
    rel_out = rel;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, d0, s0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Mixed operands, latency 8: pairs (11,9),(3,5),(15,15),(0,7) -> 339.
    pairs.delete();
    d0 = done_cnt; s0 = start_cnt;
    run(16'h0F3B, 16'h7F59, 8, 4, -1, 1'b0, rel);
    check("dir_sum", int'(bus.sum), 339);
    check("dir_done_pulses", done_cnt - d0, 1);
    check("dir_starts", start_cnt - s0, 4);
    check("dir_pairs_n", pairs.size(), 4);
    if (pairs.size() == 4) begin
      check("dir_pair0", int'(pairs[0]), 'hB9);
      check("dir_pair1", int'(pairs[1]), 'h35);
      check("dir_pair2", int'(pairs[2]), 'hFF);
      check("dir_pair3", int'(pairs[3]), 'h07);
    end
    check("dir_latency", last_done_cyc - go_cyc, 44);

    // All operands 15 -> 900.
    run(16'hFFFF, 16'hFFFF, 3, 4, -1, 1'b0, rel);
    check("max_sum", int'(bus.sum), 900);

    // Multiplier never answers the first pair -> abort after 63 WAIT cycles.
    d0 = done_cnt; s0 = start_cnt;
    run(16'h1234, 16'h5678, 5, 0, -1, 1'b0, rel);
    check("to_err", int'(bus.err), 1);
    check("to_busy", int'(bus.busy), 0);
    check("to_done_pulses", done_cnt - d0, 0);
    check("to_starts", start_cnt - s0, 1);
    check("to_cycles", rel, 65);
    check("to_sum", int'(bus.sum), 0);

    // go re-pulsed and operands scrambled mid-run: 4*8+3*7+2*6+1*5 = 70.
    run(16'h1234, 16'h5678, 4, 4, -1, 1'b1, rel);
    check("noise_sum", int'(bus.sum), 70);
    check("noise_err_cleared", int'(bus.err), 0);

    // Reset during the third pair's WAIT, then a clean run.
    d0 = done_cnt;
    run(16'h0F3B, 16'h7F59, 8, 4, 27, 1'b0, rel);
    check("rst_done_pulses", done_cnt - d0, 0);
    run(16'h0F3B, 16'h7F59, 8, 4, -1, 1'b0, rel);
    check("after_rst_sum", int'(bus.sum), 339);

    // Back-to-back: second go lands in the idle cycle right after done.
    run(16'h1234, 16'h5678, 2, 4, -1, 1'b0, rel);
    check("b2b_first", int'(bus.sum), 70);
    d0 = done_cnt;
    run(16'h0F3B, 16'h7F59, 1, 4, -1, 1'b0, rel);
    check("b2b_second", int'(bus.sum), 339);
    check("b2b_done_pulses", done_cnt - d0, 1);

    for (int r = 0; r < 40; r++) begin
      logic [15:0] ra, rb;
      int lat, st, rr;
      bit nz;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      lat = int'($urandom_range(1, 10));
      st  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : 4;
      rr  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4 * (3 + lat))) : -1;
      nz  = 1'($urandom_range(0, 1));
      run(ra, rb, lat, st, rr, nz, rel);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
